// File: rtl/uart_rx_if.sv
// Byte handshake between uart_rx and its consumer.
// The receiver drives the master side; the consumer acknowledges on the slave side.
interface uart_rx_if;
  logic [7:0] rdata;
  logic       rx_valid;
  logic       rx_ack;
  logic       ferr;
  logic       overrun;

  modport master (
    output rdata,
    output rx_valid,
    output ferr,
    output overrun,
    input  rx_ack
  );

  modport slave (
    input  rdata,
    input  rx_valid,
    input  ferr,
    input  overrun,
    output rx_ack
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, centre-of-bit sampling, valid/ack byte output.
// Framing errors and overruns are flagged alongside the delivered byte.
module uart_rx #(
  parameter int unsigned CLK_PER_HALF_BIT = 5208
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rxd_i,
  uart_rx_if.master rx
);

  localparam logic [31:0] HALF_M1 = 32'(CLK_PER_HALF_BIT - 1);
  localparam logic [31:0] FULL_M1 = 32'(2 * CLK_PER_HALF_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t      state_q;
  logic [1:0]  sync_q;
  logic [31:0] cnt_q;
  logic [2:0]  bit_idx_q;
  logic [7:0]  shreg_q;
  logic [7:0]  rdata_q;
  logic        valid_q;
  logic        ferr_q;
  logic        overrun_q;

  logic        rxd_s;
  logic [31:0] cnt_d;

  assign rxd_s = sync_q[1];
  assign cnt_d = cnt_q + 32'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= 2'b11;
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      rdata_q   <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], rxd_i};

      if (valid_q && rx.rx_ack) begin
        valid_q   <= 1'b0;
        overrun_q <= 1'b0;
      end

      unique case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (!rxd_s) state_q <= START;
        end
        START: begin
          // Mid-start-bit recheck rejects glitches shorter than half a bit.
          if (cnt_q == HALF_M1) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            state_q   <= rxd_s ? IDLE : DATA;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        DATA: begin
          if (cnt_q == FULL_M1) begin
            cnt_q     <= '0;
            shreg_q   <= {rxd_s, shreg_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) state_q <= STOP;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        STOP: begin
          // Deliver here; a same-cycle ack retires the old byte so no overrun.
          if (cnt_q == FULL_M1) begin
            cnt_q     <= '0;
            rdata_q   <= shreg_q;
            ferr_q    <= ~rxd_s;
            valid_q   <= 1'b1;
            overrun_q <= valid_q & ~rx.rx_ack;
            state_q   <= rxd_s ? IDLE : BREAK;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        BREAK: begin
          cnt_q <= '0;
          if (rxd_s) state_q <= IDLE;
        end
        default: begin
          cnt_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rx.rdata    = rdata_q;
  assign rx.rx_valid = valid_q;
  assign rx.ferr     = ferr_q;
  assign rx.overrun  = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random frames,
// with an expectation queue checked by a consumer-side monitor on every accepted byte.
module tb_uart_rx;

  localparam int H   = 4;
  localparam int BIT = 2 * H;

  typedef struct packed {
    logic [7:0] d;
    logic       f;
    logic       o;
  } exp_t;

  logic clk;
  logic rst;
  logic rxd;
  logic auto_en;
  logic auto_q;
  logic man_ack;

  exp_t exp_q[$];
  int   n_checks;
  int   n_fail;

  uart_rx_if bus();
  assign bus.rx_ack = auto_q | man_ack;

  uart_rx #(.CLK_PER_HALF_BIT(H)) dut (
    .clk  (clk),
    .rst  (rst),
    .rxd_i(rxd),
    .rx   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected byte; a delivery onto an unacked byte replaces it and sets overrun.
  task automatic model_push(input logic [7:0] d, input logic stop_bit, input logic overwrite);
    exp_t e;
    e.d = d;
    e.f = ~stop_bit;
    e.o = 1'b0;
    if (overwrite && exp_q.size() > 0) begin
      void'(exp_q.pop_back());
      e.o = 1'b1;
    end
    exp_q.push_back(e);
  endtask

  // Start bit, 8 data bits LSB first, stop bit; each held one bit period.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rxd = bits[i];
      repeat (BIT - 1) @(negedge clk);
    end
  endtask

  task automatic pulse_ack();
    @(negedge clk);
    man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
  endtask

  // Consumer: in auto mode acks each byte one cycle after it appears.
  initial begin
    auto_q = 1'b0;
    forever begin
      @(negedge clk);
      auto_q = auto_en && bus.rx_valid && !auto_q;
    end
  end

  // Monitor: every accepted byte must match the head of the expectation queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && bus.rx_valid && bus.rx_ack) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_byte: got %0h expected none", bus.rdata);
        end else begin
          e = exp_q.pop_front();
          check("rdata", 32'(bus.rdata), 32'(e.d));
          check("ferr", 32'(bus.ferr), 32'(e.f));
          check("overrun", 32'(bus.overrun), 32'(e.o));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    rxd      = 1'b1;
    man_ack  = 1'b0;
    auto_en  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rdata", 32'(bus.rdata), 32'h0);
    check("rst_valid", 32'(bus.rx_valid), 32'h0);
    check("rst_ferr", 32'(bus.ferr), 32'h0);
    check("rst_overrun", 32'(bus.overrun), 32'h0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Single byte, held until acked.
    model_push(8'hA5, 1'b1, 1'b0);
    send_frame(8'hA5, 1'b1);
    check("t1_valid", 32'(bus.rx_valid), 32'h1);
    check("t1_rdata", 32'(bus.rdata), 32'hA5);
    repeat (20) @(negedge clk);
    check("t1_valid_held", 32'(bus.rx_valid), 32'h1);
    pulse_ack();
    check("t1_valid_cleared", 32'(bus.rx_valid), 32'h0);

    // Back-to-back frames with prompt acks.
    auto_en = 1'b1;
    model_push(8'h00, 1'b1, 1'b0);
    send_frame(8'h00, 1'b1);
    model_push(8'hFF, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1);
    model_push(8'h3C, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b1);
    repeat (10) @(negedge clk);

    // Short glitch on the line.
    @(negedge clk);
    rxd = 1'b0;
    repeat (2) @(negedge clk);
    rxd = 1'b1;
    repeat (20) @(negedge clk);
    check("t3_glitch_valid", 32'(bus.rx_valid), 32'h0);
    model_push(8'h55, 1'b1, 1'b0);
    send_frame(8'h55, 1'b1);
    repeat (5) @(negedge clk);

    // Framing error followed by a held-low line.
    model_push(8'h81, 1'b0, 1'b0);
    send_frame(8'h81, 1'b0);
    repeat (40) @(negedge clk);
    check("t4_break_valid", 32'(bus.rx_valid), 32'h0);
    rxd = 1'b1;
    repeat (4) @(negedge clk);
    model_push(8'h12, 1'b1, 1'b0);
    send_frame(8'h12, 1'b1);
    repeat (5) @(negedge clk);

    // Overrun without ack.
    auto_en = 1'b0;
    repeat (2) @(negedge clk);
    model_push(8'h11, 1'b1, 1'b0);
    send_frame(8'h11, 1'b1);
    model_push(8'h22, 1'b1, 1'b1);
    send_frame(8'h22, 1'b1);
    check("t5a_valid", 32'(bus.rx_valid), 32'h1);
    check("t5a_rdata", 32'(bus.rdata), 32'h22);
    check("t5a_overrun", 32'(bus.overrun), 32'h1);
    pulse_ack();
    check("t5a_valid_after_ack", 32'(bus.rx_valid), 32'h0);
    check("t5a_overrun_after_ack", 32'(bus.overrun), 32'h0);

    // Ack lands exactly on the second deliver cycle.
    repeat (3) @(negedge clk);
    model_push(8'h11, 1'b1, 1'b0);
    send_frame(8'h11, 1'b1);
    model_push(8'h22, 1'b1, 1'b0);
    fork
      send_frame(8'h22, 1'b1);
      begin
        repeat (BIT * 9 + H + 3) @(negedge clk);
        man_ack = 1'b1;
        @(negedge clk);
        man_ack = 1'b0;
      end
    join
    check("t5b_valid", 32'(bus.rx_valid), 32'h1);
    check("t5b_rdata", 32'(bus.rdata), 32'h22);
    check("t5b_overrun", 32'(bus.overrun), 32'h0);
    pulse_ack();
    check("t5b_valid_after_ack", 32'(bus.rx_valid), 32'h0);

    // Reset in the middle of a frame while a byte is pending.
    repeat (3) @(negedge clk);
    model_push(8'hC3, 1'b0, 1'b0);
    send_frame(8'hC3, 1'b0);
    rxd = 1'b1;
    repeat (4) @(negedge clk);
    check("t6_pending_valid", 32'(bus.rx_valid), 32'h1);
    begin
      logic [8:0] part;
      part = {8'h77, 1'b0};
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        rxd = part[i];
        repeat (BIT - 1) @(negedge clk);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    rxd = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    check("t6_rst_rdata", 32'(bus.rdata), 32'h0);
    check("t6_rst_valid", 32'(bus.rx_valid), 32'h0);
    check("t6_rst_ferr", 32'(bus.ferr), 32'h0);
    check("t6_rst_overrun", 32'(bus.overrun), 32'h0);
    repeat (BIT * 10) @(negedge clk);
    check("t6_no_delivery", 32'(bus.rx_valid), 32'h0);
    auto_en = 1'b1;
    model_push(8'h99, 1'b1, 1'b0);
    send_frame(8'h99, 1'b1);
    repeat (5) @(negedge clk);

    // Random frames with random stop validity and idle gaps.
    for (int k = 0; k < 30; k++) begin
      logic [7:0] d;
      logic       sb;
      int         gap;
      d  = 8'($urandom);
      sb = ($urandom_range(0, 4) != 0);
      model_push(d, sb, 1'b0);
      send_frame(d, sb);
      if (!sb) begin
        repeat ($urandom_range(0, 20)) @(negedge clk);
        @(negedge clk);
        rxd = 1'b1;
        gap = $urandom_range(2, 6);
      end else begin
        gap = $urandom_range(0, 4);
      end
      repeat (gap) @(negedge clk);
    end

    begin
      int waited;
      waited = 0;
      while (exp_q.size() != 0 && waited < 200) begin
        @(negedge clk);
        waited++;
      end
    end
    check("queue_empty", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
